// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage sequencer: PC write/redirect control, flushes, perf counters, fault
module if_fetch_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BOOT_CYCLES = 4,
  parameter int COUNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               stall_req_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_addr_i,
  input  logic               halt_req_i,
  input  logic               resume_i,
  output logic               pc_wr_en_o,
  output logic               jump_enable_o,
  output logic [ADDR_W-1:0]  jump_address_o,
  output logic               if_id_flush_o,
  output logic               id_ex_flush_o,
  output logic               fetch_valid_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic [ADDR_W-1:0]  fault_addr_o,
  output logic [COUNT_W-1:0] fetch_cnt_o,
  output logic [COUNT_W-1:0] stall_cnt_o,
  output logic [COUNT_W-1:0] redirect_cnt_o
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e              state_q;
  logic [BW-1:0]       boot_cnt_q;
  logic                fault_q;
  logic [ADDR_W-1:0]   fault_addr_q;
  logic [COUNT_W-1:0]  fetch_cnt_q, stall_cnt_q, redirect_cnt_q;
  logic [COUNT_W-1:0]  fetch_cnt_d, stall_cnt_d, redirect_cnt_d;

  logic boot_done;
  logic ev_halt, ev_redir_ok, ev_redir_bad, ev_stall, ev_fetch;

  assign boot_done = (BOOT_CYCLES <= 1) || (boot_cnt_q == BW'(BOOT_CYCLES - 1));

  // RUN-state events, already resolved by priority halt > redirect > stall > normal.
  always_comb begin
    ev_halt      = 1'b0;
    ev_redir_ok  = 1'b0;
    ev_redir_bad = 1'b0;
    ev_stall     = 1'b0;
    ev_fetch     = 1'b0;
    if (state_q == RUN) begin
      if (halt_req_i)                           ev_halt      = 1'b1;
      else if (redirect_valid_i && redirect_addr_i[1:0] == 2'b00) ev_redir_ok = 1'b1;
      else if (redirect_valid_i)                ev_redir_bad = 1'b1;
      else if (stall_req_i)                     ev_stall     = 1'b1;
      else                                      ev_fetch     = 1'b1;
    end
  end

  always_comb begin
    pc_wr_en_o     = ev_fetch | ev_redir_ok;
    jump_enable_o  = ev_redir_ok;
    jump_address_o = ev_redir_ok ? redirect_addr_i : '0;
    if_id_flush_o  = ev_halt | ev_redir_ok | ev_redir_bad;
    id_ex_flush_o  = ev_redir_ok | ev_redir_bad;
    fetch_valid_o  = ev_fetch | ev_stall;
    halted_o       = (state_q == HALT);
  end

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (ev_fetch && fetch_cnt_q != '1)          fetch_cnt_d    = fetch_cnt_q + 1'b1;
    if (ev_stall && stall_cnt_q != '1)          stall_cnt_d    = stall_cnt_q + 1'b1;
    if (ev_redir_ok && redirect_cnt_q != '1)    redirect_cnt_d = redirect_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= BOOT;
      boot_cnt_q     <= '0;
      fault_q        <= 1'b0;
      fault_addr_q   <= '0;
      fetch_cnt_q    <= '0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      case (state_q)
        BOOT: begin
          if (boot_done) state_q    <= RUN;
          else           boot_cnt_q <= boot_cnt_q + 1'b1;
        end
        RUN: begin
          if (ev_halt) state_q <= HALT;
          if (ev_redir_bad) begin
            state_q <= HALT;
            fault_q <= 1'b1;
            if (!fault_q) fault_addr_q <= redirect_addr_i;
          end
        end
        HALT: begin
          // A fault pins the core in HALT until reset.
          if (resume_i && !halt_req_i && !fault_q) state_q <= RUN;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign fault_o        = fault_q;
  assign fault_addr_o   = fault_addr_q;
  assign fetch_cnt_o    = fetch_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl against a behavioural model
module tb_if_fetch_ctrl;
  localparam int BOOT = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_req = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] redirect_addr = '0;

  logic          pc_wr_en, jump_enable, if_id_flush, id_ex_flush, fetch_valid, halted, fault;
  logic [31:0]   jump_address, fault_addr;
  logic [CW-1:0] fetch_cnt, stall_cnt, redirect_cnt;

  logic          z_pc_wr_en, z_jump_enable, z_if_id_flush, z_id_ex_flush, z_fetch_valid, z_halted, z_fault;
  logic [31:0]   z_jump_address, z_fault_addr;
  logic [CW-1:0] z_fetch_cnt, z_stall_cnt, z_redirect_cnt;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.ADDR_W(32), .BOOT_CYCLES(BOOT), .COUNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_req_i(stall_req), .redirect_valid_i(redirect_valid),
    .redirect_addr_i(redirect_addr), .halt_req_i(halt_req), .resume_i(resume),
    .pc_wr_en_o(pc_wr_en), .jump_enable_o(jump_enable), .jump_address_o(jump_address),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .fetch_valid_o(fetch_valid),
    .halted_o(halted), .fault_o(fault), .fault_addr_o(fault_addr),
    .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt), .redirect_cnt_o(redirect_cnt)
  );

  if_fetch_ctrl #(.ADDR_W(32), .BOOT_CYCLES(0), .COUNT_W(CW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .stall_req_i(stall_req), .redirect_valid_i(redirect_valid),
    .redirect_addr_i(redirect_addr), .halt_req_i(halt_req), .resume_i(resume),
    .pc_wr_en_o(z_pc_wr_en), .jump_enable_o(z_jump_enable), .jump_address_o(z_jump_address),
    .if_id_flush_o(z_if_id_flush), .id_ex_flush_o(z_id_ex_flush), .fetch_valid_o(z_fetch_valid),
    .halted_o(z_halted), .fault_o(z_fault), .fault_addr_o(z_fault_addr),
    .fetch_cnt_o(z_fetch_cnt), .stall_cnt_o(z_stall_cnt), .redirect_cnt_o(z_redirect_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: cycles of boot left, halt/fault flags, integer counters.
  int          boot_left;
  bit          m_halt, m_fault;
  logic [31:0] m_faddr;
  int          m_fetch, m_stall, m_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic check_state();
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("fault_addr", fault_addr, m_faddr);
    chk("fetch_cnt", {28'd0, fetch_cnt}, m_fetch);
    chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
    chk("redirect_cnt", {28'd0, redirect_cnt}, m_redir);
  endtask

  // Called aligned to a negedge; returns aligned to the next negedge.
  task automatic step(input bit st, input bit rv, input logic [31:0] ra, input bit hr, input bit rs);
    bit e_pc, e_je, e_iif, e_iex, e_fv;
    logic [31:0] e_ja;
    stall_req = st; redirect_valid = rv; redirect_addr = ra; halt_req = hr; resume = rs;
    #1;
    e_pc = 0; e_je = 0; e_iif = 0; e_iex = 0; e_fv = 0; e_ja = '0;
    check_state();
    if (boot_left > 0) begin
      boot_left--;
    end else if (m_halt) begin
      if (rs && !hr && !m_fault) m_halt = 0;
    end else if (hr) begin
      e_iif = 1; m_halt = 1;
    end else if (rv && ra[1:0] == 2'b00) begin
      e_je = 1; e_ja = ra; e_pc = 1; e_iif = 1; e_iex = 1;
      m_redir = sat_inc(m_redir);
    end else if (rv) begin
      e_iif = 1; e_iex = 1; m_halt = 1;
      if (!m_fault) m_faddr = ra;
      m_fault = 1;
    end else if (st) begin
      e_fv = 1; m_stall = sat_inc(m_stall);
    end else begin
      e_pc = 1; e_fv = 1; m_fetch = sat_inc(m_fetch);
    end
    chk("pc_wr_en", {31'd0, pc_wr_en}, {31'd0, e_pc});
    chk("jump_enable", {31'd0, jump_enable}, {31'd0, e_je});
    chk("jump_address", jump_address, e_ja);
    chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_iif});
    chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_iex});
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_fv});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  // Asserts reset, checks the reset values asynchronously, releases on the next negedge.
  task automatic do_reset();
    rst_n = 0; stall_req = 1; redirect_valid = 1; redirect_addr = 32'h40; halt_req = 0; resume = 0;
    #1;
    boot_left = (BOOT > 0) ? BOOT : 1;
    m_halt = 0; m_fault = 0; m_faddr = '0; m_fetch = 0; m_stall = 0; m_redir = 0;
    chk("rst_pc_wr_en", {31'd0, pc_wr_en}, 32'd0);
    chk("rst_jump_enable", {31'd0, jump_enable}, 32'd0);
    chk("rst_jump_address", jump_address, 32'd0);
    chk("rst_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_state();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Boot hold of 4 cycles, then fetching; BOOT_CYCLES=0 instance runs after one edge.
    chk("boot0_first", {31'd0, z_pc_wr_en}, 32'd0);
    step(0, 0, '0, 0, 0);
    chk("boot0_run", {31'd0, z_pc_wr_en}, 32'd1);
    idle(3);
    idle(3);
    chk("boot_done_fetch", {28'd0, fetch_cnt}, 32'd3);

    // Three stall cycles, then fetch resumes.
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);
    idle(1);
    chk("stall_cnt_3", {28'd0, stall_cnt}, 32'd3);

    // Aligned redirect wins over a same-cycle stall.
    step(1, 1, 32'h100, 0, 0);
    idle(1);
    chk("redirect_cnt_1", {28'd0, redirect_cnt}, 32'd1);

    // Misaligned redirect: sticky fault, resume ignored, only reset clears.
    step(0, 1, 32'h102, 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    idle(1);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    do_reset();
    idle(BOOT + 1);

    // Halt beats a redirect; resume with halt_req held stays halted; plain resume returns to RUN.
    step(0, 1, 32'h200, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 1);
    idle(2);

    // Saturation at 2^CW-1, then reset mid-run.
    idle(20);
    chk("fetch_sat", {28'd0, fetch_cnt}, CMAX);
    do_reset();
    idle(BOOT + 2);

    // Randomized traffic with periodic resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 255), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      if (i % 60 == 59) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, a,
                $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
